pattern_scan_ctrl: RTL

- Shares one serial 5-bit pattern detector (default pattern 10101) between two requesters.
- Round-robin arbitration picks a requester, latches its parallel word, and feeds the word MSB-first into the detector, one bit per cycle.
- Overlap mode is selectable per job. The block counts matches and returns the count to the system through a valid/ready result port.
- Sits between the requesters and downstream result logic as the scheduler for the detector datapath.

---
 rtl/pattern_scan_if.sv | 28 ++
 rtl/pattern_scan_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pattern_scan_if.sv
// Job request / result bus between two requesters, the downstream result
// consumer and pattern_scan_ctrl.
interface pattern_scan_if #(
  parameter int WORD_W = 16,
  parameter int CNT_W  = 5
);
  logic [1:0]        req_valid;
  logic [WORD_W-1:0] req_data0;
  logic [WORD_W-1:0] req_data1;
  logic [1:0]        req_ovl;
  logic [1:0]        req_ready;
  logic              res_valid;
  logic              res_ready;
  logic              res_id;
  logic [CNT_W-1:0]  res_count;
  logic              res_hit;
  logic              busy;

  modport master (
    output req_valid, req_data0, req_data1, req_ovl, res_ready,
    input  req_ready, res_valid, res_id, res_count, res_hit, busy
  );

  modport slave (
    input  req_valid, req_data0, req_data1, req_ovl, res_ready,
    output req_ready, res_valid, res_id, res_count, res_hit, busy
  );
endinterface

// File: rtl/pattern_scan_ctrl.sv
// Round-robin scheduler feeding one serial pattern detector from two
// requesters, returning the per-word match count on a valid/ready port.
module pattern_scan_ctrl #(
  parameter int               WORD_W  = 16,
  parameter int               PAT_W   = 5,
  parameter logic [PAT_W-1:0] PATTERN = 5'b10101,
  parameter int               CNT_W   = 5
) (
  input logic           clk,
  input logic           rst,
  pattern_scan_if.slave bus
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam int BIT_W  = $clog2(WORD_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WORD_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e             state_q, state_d;
  logic               rr_q, rr_d;
  logic               id_q, id_d;
  logic               ovl_q, ovl_d;
  logic [WORD_W-1:0]  data_q, data_d;
  logic [PAT_W-1:0]   hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               hit_q, hit_d;
  logic               res_valid_q, res_valid_d;
  logic               busy_q, busy_d;

  logic               grant;
  logic               winner;
  logic [PAT_W-1:0]   hist_n;
  logic [FILL_W-1:0]  fill_n;
  logic               match;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    id_d        = id_q;
    ovl_d       = ovl_q;
    data_d      = data_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    bit_d       = bit_q;
    count_d     = count_q;
    hit_d       = hit_q;
    res_valid_d = res_valid_q;
    busy_d      = busy_q;
    grant       = 1'b0;
    winner      = 1'b0;

    // data_q shifts left each SHIFT cycle, so its MSB is always the next bit
    hist_n = {hist_q[PAT_W-2:0], data_q[WORD_W-1]};
    fill_n = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
    match  = (fill_n == FILL_FULL) && (hist_n == PATTERN);

    case (state_q)
      IDLE: begin
        if (bus.req_valid != 2'b00) begin
          grant   = 1'b1;
          winner  = (bus.req_valid == 2'b11) ? rr_q : bus.req_valid[1];
          rr_d    = ~winner;
          id_d    = winner;
          data_d  = winner ? bus.req_data1 : bus.req_data0;
          ovl_d   = bus.req_ovl[winner];
          hist_d  = '0;
          fill_d  = '0;
          bit_d   = '0;
          count_d = '0;
          hit_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        hist_d = hist_n;
        fill_d = fill_n;
        data_d = data_q << 1;
        bit_d  = bit_q + 1'b1;
        if (match) begin
          if (count_q != '1) count_d = count_q + 1'b1;
          // non-overlapping mode needs a full fresh window for the next hit
          if (!ovl_q) fill_d = '0;
        end
        hit_d = (count_d != '0);
        if (bit_q == LAST_BIT) begin
          res_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      id_q        <= 1'b0;
      ovl_q       <= 1'b0;
      data_q      <= '0;
      hist_q      <= '0;
      fill_q      <= '0;
      bit_q       <= '0;
      count_q     <= '0;
      hit_q       <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      id_q        <= id_d;
      ovl_q       <= ovl_d;
      data_q      <= data_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      bit_q       <= bit_d;
      count_q     <= count_d;
      hit_q       <= hit_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Accept pulse coincides with the IDLE cycle that sees the request; held
  // low while reset is asserted so a parked request is never acknowledged.
  assign bus.req_ready = (grant && rst) ? (winner ? 2'b10 : 2'b01) : 2'b00;
  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = id_q;
  assign bus.res_count = count_q;
  assign bus.res_hit   = hit_q;
  assign bus.busy      = busy_q;

endmodule
